// File: rtl/instr_register_pkg.sv
// Shared instruction-register types: opcode, operand and packed instruction word.
package instr_register_pkg;

  localparam int DEPTH = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_register.sv
// Instruction register storage: one synchronous write port, one combinational read port.
module instr_register
  import instr_register_pkg::*;
#(
  parameter int DEPTH = instr_register_pkg::DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_en,
  input  logic               load_en,
  input  logic [IDX_W-1:0]   write_index,
  input  opcode_t            opcode,
  input  operand_t           operand_a,
  input  operand_t           operand_b,
  input  logic [IDX_W-1:0]   read_index,
  output instruction_t       instruction
);

  instruction_t mem_r [DEPTH];

  // Entry storage; contents survive a controller flush and clear only on reset
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (load_en) begin
      mem_r[write_index] <= {opcode, operand_a, operand_b};
    end
  end

  assign instruction = mem_r[read_index];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_en,
  input  logic       clr,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic       last_grant_r;
  logic [1:0] grant_s;

  // Winner selection from current requests and the last served requester
  always_comb begin
    grant_s = 2'b00;
    case (valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  assign grant = reset_en ? grant_s : 2'b00;

  // Fairness state moves only when the granted push is actually accepted
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      last_grant_r <= 1'b1;
    end else if (clr) begin
      last_grant_r <= 1'b1;
    end else if (accept) begin
      last_grant_r <= grant_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/instr_register_ctrl.sv
// Sequencing controller: arbitrates two producers into the instruction register
// as a circular queue and drains it in order through a registered output stage.
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int DEPTH = instr_register_pkg::DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_en,
  input  logic               clr,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  instruction_t       req0_instr,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  instruction_t       req1_instr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output instruction_t       rsp_instr,
  output logic               load_en,
  output logic [IDX_W-1:0]   write_index,
  output opcode_t            opcode,
  output operand_t           operand_a,
  output operand_t           operand_b,
  output logic [IDX_W-1:0]   read_index,
  input  instruction_t       instruction,
  output logic [IDX_W:0]     count,
  output logic               full,
  output logic               empty
);

  localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] ptr);
    if (ptr == LAST_IDX) begin
      return {IDX_W{1'b0}};
    end else begin
      return ptr + IDX_W'(1'b1);
    end
  endfunction

  logic [IDX_W-1:0] wr_ptr_r;
  logic [IDX_W-1:0] rd_ptr_r;
  logic [IDX_W:0]   count_r;
  logic             rsp_valid_r;
  instruction_t     rsp_instr_r;

  logic [1:0]       grant_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  instruction_t     win_instr_s;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset_en (reset_en),
    .clr      (clr),
    .valid    ({req1_valid, req0_valid}),
    .accept   (push_s),
    .grant    (grant_s)
  );

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == {(IDX_W+1){1'b0}});

  // Push decision and winner data; a full queue refuses even with a same-cycle pop
  always_comb begin
    push_s      = 1'b0;
    win_instr_s = '0;
    if (reset_en && !full_s && !clr) begin
      push_s = (grant_s[0] && req0_valid) || (grant_s[1] && req1_valid);
    end else begin
      push_s = 1'b0;
    end
    if (grant_s[1]) begin
      win_instr_s = req1_instr;
    end else begin
      win_instr_s = req0_instr;
    end
  end

  assign pop_s = reset_en && !empty_s && (!rsp_valid_r || rsp_ready) && !clr;

  assign req0_ready  = reset_en && grant_s[0] && !full_s && !clr;
  assign req1_ready  = reset_en && grant_s[1] && !full_s && !clr;
  assign load_en     = push_s;
  assign write_index = wr_ptr_r;
  assign read_index  = rd_ptr_r;
  assign opcode      = push_s ? win_instr_s.opc  : ZERO;
  assign operand_a   = push_s ? win_instr_s.op_a : 32'sd0;
  assign operand_b   = push_s ? win_instr_s.op_b : 32'sd0;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_instr   = rsp_instr_r;
  assign count       = count_r;
  assign full        = full_s;
  assign empty       = empty_s;

  // Pointers, occupancy and output stage; flush leaves register contents alone
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      wr_ptr_r    <= {IDX_W{1'b0}};
      rd_ptr_r    <= {IDX_W{1'b0}};
      count_r     <= {(IDX_W+1){1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= '0;
    end else if (clr) begin
      wr_ptr_r    <= {IDX_W{1'b0}};
      rd_ptr_r    <= {IDX_W{1'b0}};
      count_r     <= {(IDX_W+1){1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= rsp_instr_r;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r    <= ptr_next(rd_ptr_r);
        rsp_instr_r <= instruction;
        rsp_valid_r <= 1'b1;
      end else if (rsp_valid_r && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (IDX_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (IDX_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl driving a real instr_register, with an in-order scoreboard.
module tb_instr_register_ctrl;
  import instr_register_pkg::*;

  localparam int D  = DEPTH;
  localparam int IW = $clog2(D);

  logic clk = 1'b0;
  logic reset_en, clr, req0_valid, req1_valid, rsp_ready;
  logic req0_ready, req1_ready, rsp_valid, load_en, full, empty;
  instruction_t req0_instr, req1_instr, rsp_instr, instruction;
  opcode_t  opcode;
  operand_t operand_a, operand_b;
  logic [IW-1:0] write_index, read_index;
  logic [IW:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  instruction_t sb_q[$];
  instruction_t mon_e, hold_val, got_front;
  int exp_wr, exp_rd, cnt_max;
  bit hold_pend, wr_wrapped, rd_wrapped;
  instruction_t single_v[4];

  instr_register_ctrl dut (
    .clk(clk), .reset_en(reset_en), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .load_en(load_en), .write_index(write_index),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_index(read_index), .instruction(instruction),
    .count(count), .full(full), .empty(empty)
  );

  instr_register u_reg (
    .clk(clk), .reset_en(reset_en), .load_en(load_en), .write_index(write_index),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_index(read_index), .instruction(instruction)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t o, input int a, input int b);
    instruction_t r;
    r.opc  = o;
    r.op_a = a;
    r.op_b = b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    sb_q.delete();
    exp_wr    = 0;
    exp_rd    = 0;
    hold_pend = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    while (!(empty && !rsp_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", empty && !rsp_valid, 1'b1);
    chk("drain_sb_left", sb_q.size(), 0);
  endtask

  // Monitor: sampled mid-cycle, when inputs for the coming edge are stable
  always @(negedge clk) begin
    if (reset_en) begin
      if (hold_pend) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_instr", rsp_instr, hold_val);
      end
      hold_pend = 1'b0;
      if (int'(count) > cnt_max) cnt_max = int'(count);
      if (clr) begin
        chk("clr_no_load", load_en, 1'b0);
        flush_model();
      end else begin
        if (load_en) begin
          mon_e = req1_ready ? req1_instr : req0_instr;
          chk("wr_idx", write_index, exp_wr[IW-1:0]);
          chk("wr_data", {opcode, operand_a, operand_b}, mon_e);
          if (int'(write_index) == D-1) wr_wrapped = 1'b1;
          sb_q.push_back(mon_e);
          exp_wr = (exp_wr + 1) % D;
        end
        if (!empty && (!rsp_valid || rsp_ready)) begin
          chk("rd_idx", read_index, exp_rd[IW-1:0]);
          if (int'(read_index) == D-1) rd_wrapped = 1'b1;
          exp_rd = (exp_rd + 1) % D;
        end
        if (rsp_valid && rsp_ready) begin
          chk("sb_avail", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            got_front = sb_q.pop_front();
            chk("rsp_order", rsp_instr, got_front);
          end
        end
        if (rsp_valid && !rsp_ready) begin
          hold_pend = 1'b1;
          hold_val  = rsp_instr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, summary not reached");
    $fatal(1);
  end

  initial begin
    int acc, cyc;
    single_v[0] = mk(ADD, 5, 7);
    single_v[1] = mk(SUB, 9, 3);
    single_v[2] = mk(MULT, 4, 6);
    single_v[3] = mk(DIV, 20, 4);
    reset_en = 1'b0; clr = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_instr = mk(ADD, 1, 1); req1_instr = mk(SUB, 2, 2);
    flush_model(); cnt_max = 0; wr_wrapped = 1'b0; rd_wrapped = 1'b0;
    tick(); tick();

    // Reset state, with both requesters valid to show outputs are forced low
    chk("rst_rdy0", req0_ready, 1'b0);
    chk("rst_rdy1", req1_ready, 1'b0);
    chk("rst_load", load_en, 1'b0);
    chk("rst_widx", write_index, 5'd0);
    chk("rst_ridx", read_index, 5'd0);
    chk("rst_opc", opcode, 4'd0);
    chk("rst_opa", operand_a, 32'd0);
    chk("rst_rspv", rsp_valid, 1'b0);
    chk("rst_rspi", rsp_instr, 68'd0);
    chk("rst_count", count, 6'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_en = 1'b1;
    tick();

    // Single requester, consumer always ready
    cnt_max = 0; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_instr = single_v[k];
      #1;
      chk("s_widx", write_index, k[IW-1:0]);
      chk("s_load", load_en, 1'b1);
      tick();
      if (k == 0) begin
        chk("s_lat0", rsp_valid, 1'b0);
      end else begin
        chk("s_valid", rsp_valid, 1'b1);
        chk("s_instr", rsp_instr, single_v[k-1]);
      end
    end
    req0_valid = 1'b0;
    tick();
    chk("s_last_valid", rsp_valid, 1'b1);
    chk("s_last_instr", rsp_instr, single_v[3]);
    chk("s_cnt_max", cnt_max, 1);
    drain(10);

    // Round-robin after a flush: req0 wins first tie, then strict alternation
    clr = 1'b1; tick(); clr = 1'b0;
    rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_instr = mk(ADD, 100 + k, k);
      req1_instr = mk(SUB, 200 + k, k);
      #1;
      chk("rr_g0", req0_ready, (k % 2) == 0);
      chk("rr_g1", req1_ready, (k % 2) == 1);
      chk("rr_widx", write_index, k[IW-1:0]);
      tick();
    end
    drain(20);

    // Full: DEPTH in the register plus one held in the output stage
    rsp_ready = 1'b0; req0_valid = 1'b1;
    for (int k = 0; k < D + 1; k++) begin
      req0_instr = mk(MOD, 300 + k, k);
      tick();
    end
    chk("full_flag", full, 1'b1);
    chk("full_count", count, 6'd32);
    chk("full_stage_v", rsp_valid, 1'b1);
    chk("full_stage_i", rsp_instr, mk(MOD, 300, 0));
    req0_instr = mk(MOD, 999, 9);
    req1_valid = 1'b1; req1_instr = mk(PASSA, 1, 2);
    #1;
    chk("full_rdy0", req0_ready, 1'b0);
    chk("full_rdy1", req1_ready, 1'b0);
    chk("full_load", load_en, 1'b0);
    tick();
    req1_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("full_pop_rdy0", req0_ready, 1'b0);
    chk("full_pop_load", load_en, 1'b0);
    tick();
    chk("full_release_rdy", req0_ready, 1'b1);
    chk("full_release_cnt", count, 6'd31);
    drain(100);

    // Wrap-around with a consumer ready every other cycle
    cnt_max = 0; acc = 0; cyc = 0;
    while (acc < 2*D + 3 && cyc < 1000) begin
      req0_valid = 1'b1; req0_instr = mk(ADD, 1000 + acc, acc); rsp_ready = cyc[0];
      @(negedge clk);
      if (req0_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("wrap_pushes", acc, 2*D + 3);
    drain(200);
    chk("wrap_cnt_max", cnt_max <= D, 1'b1);
    chk("wrap_wr", wr_wrapped, 1'b1);
    chk("wrap_rd", rd_wrapped, 1'b1);

    // Random backpressure and bursty requester
    acc = 0; cyc = 0;
    while (acc < 20 && cyc < 1000) begin
      req0_valid = 1'($urandom_range(0, 1)); req0_instr = mk(PASSB, 2000 + acc, acc);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req0_ready && req0_valid) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_pushes", acc, 20);
    drain(100);

    // Flush with five entries queued behind a held output
    rsp_ready = 1'b0; req0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_instr = mk(SUB, 500 + k, k);
      tick();
    end
    req0_valid = 1'b0;
    chk("c_count5", count, 6'd5);
    clr = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("c_rdy0", req0_ready, 1'b0);
    chk("c_rdy1", req1_ready, 1'b0);
    chk("c_load", load_en, 1'b0);
    tick();
    clr = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("c_count", count, 6'd0);
    chk("c_empty", empty, 1'b1);
    chk("c_rspv", rsp_valid, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_instr = mk(ADD, 600, 1); req1_instr = mk(SUB, 601, 1);
    #1;
    chk("c_tie_rdy0", req0_ready, 1'b1);
    chk("c_tie_rdy1", req1_ready, 1'b0);
    chk("c_tie_widx", write_index, 5'd0);
    tick();

    // Asynchronous reset in the middle of a push
    req0_instr = mk(ADD, 602, 2);
    #1;
    reset_en = 1'b0;
    flush_model();
    #1;
    chk("r_count", count, 6'd0);
    chk("r_empty", empty, 1'b1);
    chk("r_rspv", rsp_valid, 1'b0);
    chk("r_load", load_en, 1'b0);
    chk("r_rdy1", req1_ready, 1'b0);
    chk("r_widx", write_index, 5'd0);
    @(posedge clk); #1;
    reset_en = 1'b1;
    #1;
    chk("r_tie_rdy0", req0_ready, 1'b1);
    chk("r_tie_rdy1", req1_ready, 1'b0);
    chk("r_tie_widx", write_index, 5'd0);
    tick();
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
